// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory-side bridge: size codes, regions, FSM states,
// the latched access descriptor and default region bases.
package cpu_bus_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [1:0]      size_t;

  localparam size_t SZ_BYTE = 2'd0;
  localparam size_t SZ_HALF = 2'd1;
  localparam size_t SZ_WORD = 2'd2;
  localparam size_t SZ_BAD  = 2'd3;

  typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_VGA, REG_NONE} region_e;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_VGA, RESP} state_e;

  localparam word_t ROM_BASE_DEF = 32'hb000_0000;
  localparam word_t RAM_BASE_DEF = 32'h0000_0000;
  localparam word_t VGA_BASE_DEF = 32'hc000_0000;

  // What must survive from acceptance to the response.
  typedef struct packed {
    logic    we;
    size_t   size;
    logic [1:0] lane;
    region_e region;
  } acc_t;

  // Region hit: top nibble matches and offset lies inside the 4<<aw byte window.
  function automatic logic region_hit(word_t addr, logic [3:0] base_nib, int unsigned aw);
    return (addr[31:28] == base_nib) && (addr[27:0] < 28'(32'd4 << aw));
  endfunction

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// CPU-side request/response channel of the bridge.
interface cpu_bus_bridge_if;
  import cpu_bus_pkg::*;

  logic  req_valid;
  logic  req_ready;
  word_t req_addr;
  logic  req_we;
  size_t req_size;
  word_t req_wdata;
  logic  rsp_valid;
  word_t rsp_data;
  logic  rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/cpu_bus_bridge_lane.sv
// Little-endian byte-lane steering: enables, positioned write data,
// right-justified zero-extended load data and misalignment detection.
module bus_lane_align
  import cpu_bus_pkg::*;
(
  input  logic [1:0] lane,
  input  size_t      size,
  input  word_t      wdata,
  input  word_t      rdata,
  output logic [3:0] be,
  output word_t      wdata_pos,
  output word_t      rdata_ext,
  output logic       misaligned
);

  word_t shifted;

  always_comb begin
    be         = 4'b0000;
    wdata_pos  = wdata;
    misaligned = 1'b0;
    shifted    = rdata >> {lane, 3'b000};
    rdata_ext  = shifted;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_pos = {4{wdata[7:0]}};
        rdata_ext = {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        be         = 4'b0011 << lane;
        wdata_pos  = {2{wdata[15:0]}};
        rdata_ext  = {16'h0, shifted[15:0]};
        misaligned = lane[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = |lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_bus_bridge.sv
// CPU memory-side bridge: decodes one request at a time onto boot ROM, RAM or
// the VGA framebuffer and returns data or an error as a one-cycle response.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter word_t       ROM_BASE = ROM_BASE_DEF,
  parameter int unsigned ROM_AW   = 10,
  parameter word_t       RAM_BASE = RAM_BASE_DEF,
  parameter int unsigned RAM_AW   = 12,
  parameter word_t       VGA_BASE = VGA_BASE_DEF,
  parameter int unsigned VGA_AW   = 14,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  cpu_bus_bridge_if.slave   bus,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  word_t             rom_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output word_t             ram_wdata,
  input  word_t             ram_rdata,
  output logic              vga_req,
  output logic [3:0]        vga_we,
  output logic [VGA_AW-1:0] vga_addr,
  output word_t             vga_wdata,
  input  logic              vga_ack,
  input  word_t             vga_rdata
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e  state, state_n;
  logic    phase, phase_n;
  acc_t    acc_q, acc_n;
  logic [TW-1:0] tcnt, tcnt_n;

  logic    ready_q, ready_n;
  logic    rsp_valid_q, rsp_valid_n;
  word_t   rsp_data_q, rsp_data_n;
  logic    rsp_err_q, rsp_err_n;

  logic              rom_en_n, ram_en_n, vga_req_n;
  logic [ROM_AW-1:0] rom_addr_n;
  logic [3:0]        ram_we_n, vga_we_n;
  logic [RAM_AW-1:0] ram_addr_n;
  logic [VGA_AW-1:0] vga_addr_n;
  word_t             ram_wdata_n, vga_wdata_n;

  region_e    region_in;
  logic       dec_err, accept;
  logic [1:0] lane_sel;
  size_t      size_sel;
  word_t      rdata_sel, wdata_pos, rdata_ext;
  logic [3:0] be;
  logic       misaligned;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept = bus.req_valid && ready_q;

  // Lane logic sees the live request while idle, the latched one afterwards.
  assign lane_sel = (state == IDLE) ? bus.req_addr[1:0] : acc_q.lane;
  assign size_sel = (state == IDLE) ? bus.req_size      : acc_q.size;

  always_comb begin
    rdata_sel = ram_rdata;
    if (state == WAIT_VGA)              rdata_sel = vga_rdata;
    else if (acc_q.region == REG_ROM)   rdata_sel = rom_rdata;
  end

  bus_lane_align u_lane (
    .lane       (lane_sel),
    .size       (size_sel),
    .wdata      (bus.req_wdata),
    .rdata      (rdata_sel),
    .be         (be),
    .wdata_pos  (wdata_pos),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  always_comb begin
    region_in = REG_NONE;
    if (region_hit(bus.req_addr, ROM_BASE[31:28], ROM_AW))      region_in = REG_ROM;
    else if (region_hit(bus.req_addr, RAM_BASE[31:28], RAM_AW)) region_in = REG_RAM;
    else if (region_hit(bus.req_addr, VGA_BASE[31:28], VGA_AW)) region_in = REG_VGA;
  end

  assign dec_err = (region_in == REG_NONE) || (bus.req_size == SZ_BAD) || misaligned ||
                   (bus.req_we && (region_in == REG_ROM));

  // Next-state and next-output logic; ACCESS spans the enable cycle (phase 0)
  // and the cycle the synchronous target returns data (phase 1).
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    acc_n       = acc_q;
    tcnt_n      = tcnt;
    rsp_data_n  = '0;
    rsp_err_n   = 1'b0;
    rom_en_n    = 1'b0;
    rom_addr_n  = rom_addr;
    ram_en_n    = 1'b0;
    ram_we_n    = 4'b0000;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    vga_req_n   = vga_req;
    vga_we_n    = vga_we;
    vga_addr_n  = vga_addr;
    vga_wdata_n = vga_wdata;

    case (state)
      IDLE: begin
        if (accept) begin
          acc_n = '{we: bus.req_we, size: bus.req_size, lane: bus.req_addr[1:0], region: region_in};
          if (dec_err) begin
            state_n   = RESP;
            rsp_err_n = 1'b1;
          end else begin
            case (region_in)
              REG_ROM: begin
                state_n    = ACCESS;
                phase_n    = 1'b0;
                rom_en_n   = 1'b1;
                rom_addr_n = bus.req_addr[ROM_AW+1:2];
              end
              REG_RAM: begin
                state_n     = ACCESS;
                phase_n     = 1'b0;
                ram_en_n    = 1'b1;
                ram_we_n    = bus.req_we ? be : 4'b0000;
                ram_addr_n  = bus.req_addr[RAM_AW+1:2];
                ram_wdata_n = wdata_pos;
              end
              REG_VGA: begin
                state_n     = WAIT_VGA;
                tcnt_n      = '0;
                vga_req_n   = 1'b1;
                vga_we_n    = bus.req_we ? be : 4'b0000;
                vga_addr_n  = bus.req_addr[VGA_AW+1:2];
                vga_wdata_n = wdata_pos;
              end
              default: ;
            endcase
          end
        end
      end
      ACCESS: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n    = 1'b0;
          state_n    = RESP;
          rsp_data_n = acc_q.we ? '0 : rdata_ext;
        end
      end
      WAIT_VGA: begin
        tcnt_n = tcnt + TW'(1);
        if (vga_ack) begin
          state_n    = RESP;
          vga_req_n  = 1'b0;
          vga_we_n   = 4'b0000;
          rsp_data_n = acc_q.we ? '0 : rdata_ext;
        end else if (tcnt_n == TW'(TIMEOUT)) begin
          state_n   = RESP;
          vga_req_n = 1'b0;
          vga_we_n  = 4'b0000;
          rsp_err_n = 1'b1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    rsp_valid_n = (state_n == RESP);
    ready_n     = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= 1'b0;
      acc_q       <= '0;
      tcnt        <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 4'b0000;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      vga_req     <= 1'b0;
      vga_we      <= 4'b0000;
      vga_addr    <= '0;
      vga_wdata   <= '0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      acc_q       <= acc_n;
      tcnt        <= tcnt_n;
      ready_q     <= ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      rsp_err_q   <= rsp_err_n;
      rom_en      <= rom_en_n;
      rom_addr    <= rom_addr_n;
      ram_en      <= ram_en_n;
      ram_we      <= ram_we_n;
      ram_addr    <= ram_addr_n;
      ram_wdata   <= ram_wdata_n;
      vga_req     <= vga_req_n;
      vga_we      <= vga_we_n;
      vga_addr    <= vga_addr_n;
      vga_wdata   <= vga_wdata_n;
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Bench for cpu_bus_bridge: directed requests push expected responses to a
// queue; a monitor checks each response plus the target activity behind it.
module tb_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        vga_req;
  logic [3:0]  vga_we;
  logic [13:0] vga_addr;
  logic [31:0] vga_wdata;
  logic        vga_ack = 1'b0;
  logic [31:0] vga_rdata = 32'h5566_7788;

  cpu_bus_bridge_if bus ();

  cpu_bus_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .vga_req   (vga_req),
    .vga_we    (vga_we),
    .vga_addr  (vga_addr),
    .vga_wdata (vga_wdata),
    .vga_ack   (vga_ack),
    .vga_rdata (vga_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          rom_n;
    int          ram_n;
    int          vga_n;
    int          taddr;
    logic [3:0]  twe;
    logic [31:0] twd;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ack_delay = 0;
  int   vga_cnt = 0;

  bit [31:0] rom_mem [0:1023];
  bit [31:0] ram_mem [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous target models.
  always @(posedge clk) begin
    if (rom_en) rom_rdata <= rom_mem[rom_addr];
    if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // VGA acks in the ack_delay-th cycle of vga_req; 0 means never.
  always @(negedge clk) begin
    if (vga_req) vga_cnt = vga_cnt + 1;
    else         vga_cnt = 0;
    vga_ack = vga_req && (vga_cnt == ack_delay);
  end

  task automatic chk(input string tname, input string field, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", tname, field, act, want);
    end
  endtask

  function automatic exp_t mk(string n, logic [31:0] d, logic er, int l, int rn, int an,
                              int vn, int ta, logic [3:0] we, logic [31:0] wd);
    exp_t m;
    m.name = n; m.data = d; m.err = er; m.lat = l;
    m.rom_n = rn; m.ram_n = an; m.vga_n = vn; m.taddr = ta;
    m.twe = we; m.twd = wd; m.acc = 0;
    return m;
  endfunction

  // Monitor: accumulates target activity, checks it on each response.
  int          m_rom, m_ram, m_vga, m_tad;
  logic [3:0]  m_we;
  logic [31:0] m_wd;
  bit          prev_rsp;

  task automatic m_clear();
    m_rom = 0; m_ram = 0; m_vga = 0; m_tad = -1; m_we = 4'b0000; m_wd = '0;
  endtask

  task automatic note_addr(input int a);
    if (m_tad == -1)     m_tad = a;
    else if (m_tad != a) m_tad = -2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      m_clear();
      prev_rsp = 1'b0;
    end else begin
      if (prev_rsp) begin
        chk("after_rsp", "rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("after_rsp", "req_ready", 32'(bus.req_ready), 32'd1);
      end
      if (rom_en) begin m_rom++; note_addr(int'(rom_addr)); end
      if (ram_en) begin
        m_ram++; note_addr(int'(ram_addr)); m_we |= ram_we;
        if (|ram_we) m_wd = ram_wdata;
      end
      if (vga_req) begin
        m_vga++; note_addr(int'(vga_addr)); m_we |= vga_we;
        if (|vga_we) m_wd = vga_wdata;
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp got data=%0h err=%0b want none", bus.rsp_data, bus.rsp_err);
        end else begin
          e = exp_q.pop_front();
          chk(e.name, "data",    bus.rsp_data,       e.data);
          chk(e.name, "err",     32'(bus.rsp_err),   32'(e.err));
          chk(e.name, "latency", 32'(cyc - e.acc),   32'(e.lat));
          chk(e.name, "rom_en",  32'(m_rom),         32'(e.rom_n));
          chk(e.name, "ram_en",  32'(m_ram),         32'(e.ram_n));
          chk(e.name, "vga_req", 32'(m_vga),         32'(e.vga_n));
          chk(e.name, "taddr",   32'(m_tad),         32'(e.taddr));
          chk(e.name, "we",      32'(m_we),          32'(e.twe));
          chk(e.name, "wdata",   m_wd,               e.twd);
          chk(e.name, "req_in_rsp", 32'(vga_req),    32'd0);
        end
        m_clear();
      end
      prev_rsp = bus.rsp_valid;
    end
  end

  task automatic send(input logic [31:0] a, input logic we, input logic [1:0] sz,
                      input logic [31:0] wd, input int dly, input bit push_it, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL %s.ready_wait got=0 want=1", e.name);
      return;
    end
    ack_delay     = dly;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_wdata = wd;
    e.acc = cyc + 1;
    if (push_it) exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && n < 2000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
  endtask

  task automatic chk_idle(input string tname);
    chk(tname, "req_ready", 32'(bus.req_ready), 32'd1);
    chk(tname, "rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk(tname, "vga_req",   32'(vga_req),       32'd0);
    chk(tname, "rom_en",    32'(rom_en),        32'd0);
    chk(tname, "ram_en",    32'(ram_en),        32'd0);
  endtask

  exp_t none;
  initial begin
    none = mk("noexp", 0, 0, 0, 0, 0, 0, -1, 0, 0);
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_wdata = '0;
    rom_mem[1]    = 32'h1a20_cafe;
    rom_mem[1023] = 32'hdead_beef;
    ram_mem[0]   <= 32'hbeef_cafe;

    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset", "ram_we",   32'(ram_we),        32'd0);
    chk("reset", "vga_we",   32'(vga_we),        32'd0);
    chk("reset", "rsp_err",  32'(bus.rsp_err),   32'd0);
    chk("reset", "rsp_data", bus.rsp_data,       32'd0);
    reset = 1'b1;

    send(32'hb000_0004, 0, 2, 0, 0, 1, mk("rom_fetch", 32'h1a20_cafe, 0, 2, 1, 0, 0, 1, 4'h0, 0));
    send(32'h0000_0103, 1, 0, 32'h0000_00a5, 0, 1, mk("ram_sb", 0, 0, 2, 0, 1, 0, 32'h40, 4'b1000, 32'ha5a5_a5a5));
    send(32'h0000_0103, 0, 0, 0, 0, 1, mk("ram_lb", 32'h0000_00a5, 0, 2, 0, 1, 0, 32'h40, 0, 0));
    send(32'h0000_0002, 0, 1, 0, 0, 1, mk("ram_lh", 32'h0000_beef, 0, 2, 0, 1, 0, 0, 0, 0));
    send(32'h0000_0011, 1, 0, 32'hffff_ff3c, 0, 1, mk("ram_sb_l1", 0, 0, 2, 0, 1, 0, 4, 4'b0010, 32'h3c3c_3c3c));
    send(32'h0000_0010, 0, 2, 0, 0, 1, mk("ram_lw", 32'h0000_3c00, 0, 2, 0, 1, 0, 4, 0, 0));
    send(32'h0000_3ffc, 1, 2, 32'h0bad_f00d, 0, 1, mk("ram_sw_top", 0, 0, 2, 0, 1, 0, 32'hfff, 4'hf, 32'h0bad_f00d));
    send(32'h0000_3ffc, 0, 2, 0, 0, 1, mk("ram_lw_top", 32'h0bad_f00d, 0, 2, 0, 1, 0, 32'hfff, 0, 0));

    send(32'h0000_0001, 0, 2, 0, 0, 1, mk("err_mis_w", 0, 1, 0, 0, 0, 0, -1, 0, 0));
    send(32'h0000_0001, 0, 1, 0, 0, 1, mk("err_mis_h", 0, 1, 0, 0, 0, 0, -1, 0, 0));
    send(32'hb000_0000, 1, 2, 32'h1111_1111, 0, 1, mk("err_rom_st", 0, 1, 0, 0, 0, 0, -1, 0, 0));
    send(32'h7000_0000, 0, 2, 0, 0, 1, mk("err_nomap", 0, 1, 0, 0, 0, 0, -1, 0, 0));
    send(32'h0000_0000, 0, 3, 0, 0, 1, mk("err_size3", 0, 1, 0, 0, 0, 0, -1, 0, 0));
    send(32'h0000_4000, 0, 2, 0, 0, 1, mk("err_ram_oob", 0, 1, 0, 0, 0, 0, -1, 0, 0));
    send(32'hb000_1000, 0, 2, 0, 0, 1, mk("err_rom_oob", 0, 1, 0, 0, 0, 0, -1, 0, 0));
    send(32'hb000_0ffc, 0, 2, 0, 0, 1, mk("rom_top", 32'hdead_beef, 0, 2, 1, 0, 0, 32'h3ff, 0, 0));

    send(32'hc000_0010, 1, 2, 32'h1234_5678, 5, 1, mk("vga_sw", 0, 0, 5, 0, 0, 5, 4, 4'hf, 32'h1234_5678));
    send(32'hc000_0006, 0, 1, 0, 2, 1, mk("vga_lh", 32'h0000_5566, 0, 2, 0, 0, 2, 1, 0, 0));
    send(32'hc000_0000, 0, 2, 0, 0, 1, mk("vga_tmo", 0, 1, 255, 0, 0, 255, 0, 0, 0));
    drain();

    // Reset while ACCESS is in flight: no response may follow.
    send(32'h0000_0000, 0, 2, 0, 0, 0, none);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("rst_access");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Reset while waiting on a VGA ack that never comes.
    send(32'hc000_0000, 0, 2, 0, 0, 0, none);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("rst_vga");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    send(32'hb000_0004, 0, 2, 0, 0, 1, mk("rom_after_rst", 32'h1a20_cafe, 0, 2, 1, 0, 0, 1, 4'h0, 0));
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
